// File: rtl/dmem_defs.sv
// dmem_defs: shared store/load format codes and the write-buffer entry type
package dmem_defs;
  localparam logic [2:0] FMT_SB = 3'b000;
  localparam logic [2:0] FMT_SH = 3'b001;
  localparam logic [2:0] FMT_SW = 3'b010;
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wrEntry_t;
endpackage

// File: rtl/dmem_store_fifo.sv
// dmem_store_fifo: sync write buffer taking 0/1/2 pushes and 0/1 pop per cycle
module dmem_store_fifo
  import dmem_defs::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 pushCnt,
  input  wrEntry_t                   push0,
  input  wrEntry_t                   push1,
  input  logic                       pop,
  output wrEntry_t                   head,
  output wrEntry_t                   second,
  output logic [$clog2(BUF_DEPTH):0] count
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  wrEntry_t mem [BUF_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr, wrNext, rdNext;
  assign wrNext = wrPtr + PW'(1);
  assign rdNext = rdPtr + PW'(1);
  assign head   = mem[rdPtr];
  assign second = mem[rdNext];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushCnt != 2'd0) mem[wrPtr] <= push0;
      if (pushCnt == 2'd2) mem[wrNext] <= push1;
      wrPtr <= wrPtr + PW'(pushCnt);
      rdPtr <= rdPtr + PW'(pop);
      count <= count + CW'(pushCnt) - CW'(pop);
    end
  end
endmodule

// File: rtl/dmem_store_unit.sv
// dmem_store_unit: lane-steers stores into a write buffer drained over req/ack
// Define DMEM_STORE_SPLIT_EN to split misaligned SH/SW into one or two beats instead of dropping them.
module dmem_store_unit
  import dmem_defs::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int LENGTH_MUX        = 3,
  parameter int BUF_DEPTH         = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [WIDTH_DATA_LENGTH-1:0] st_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] st_data,
  input  logic [LENGTH_MUX-1:0]        st_fmt,
  output logic                         mem_req,
  input  logic                         mem_ack,
  output logic [WIDTH_DATA_LENGTH-1:0] mem_addr,
  output logic [WIDTH_DATA_LENGTH-1:0] mem_wdata,
  output logic [3:0]                   mem_wstrb,
  output logic                         st_err,
  output logic                         buf_empty
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic [CW-1:0] count, remaining;
  logic [1:0] off, pushCnt;
  logic [3:0] byteMask;
  logic [7:0] strb8;
  logic [31:0] dataMasked;
  logic [63:0] shifted;
  logic illegal, misaligned, dropErr, accept, pop, errQ;
  wrEntry_t lowEntry, highEntry, head, second, nextOut, outQ;
  always_comb begin
    off        = st_addr[1:0];
    byteMask   = st_fmt == FMT_SB ? 4'b0001 : st_fmt == FMT_SH ? 4'b0011 : 4'b1111;
    dataMasked = st_data & {{8{byteMask[3]}}, {8{byteMask[2]}}, {8{byteMask[1]}}, {8{byteMask[0]}}};
    shifted    = {32'b0, dataMasked} << {off, 3'b000};
    strb8      = {4'b0, byteMask} << off;
    illegal    = !(st_fmt inside {FMT_SB, FMT_SH, FMT_SW});
    misaligned = (st_fmt == FMT_SH && off[0]) || (st_fmt == FMT_SW && off != 2'd0);
`ifdef DMEM_STORE_SPLIT_EN
    dropErr    = illegal;
    st_ready   = rst_n && count <= CW'(BUF_DEPTH - 2);
    accept     = st_valid && st_ready;
    pushCnt    = accept && !dropErr ? (strb8[7:4] != 4'd0 ? 2'd2 : 2'd1) : 2'd0;
`else
    dropErr    = illegal || misaligned;
    st_ready   = rst_n && count < CW'(BUF_DEPTH);
    accept     = st_valid && st_ready;
    pushCnt    = accept && !dropErr ? 2'd1 : 2'd0;
`endif
    lowEntry   = '{addr: st_addr[31:2], wdata: shifted[31:0], wstrb: strb8[3:0]};
    highEntry  = '{addr: st_addr[31:2] + 30'd1, wdata: shifted[63:32], wstrb: strb8[7:4]};
    pop        = mem_req && mem_ack;
    remaining  = count - CW'(pop);
    // Output registers preload whatever entry will sit at the head after this edge.
    nextOut    = remaining != '0 ? (pop ? second : head) : pushCnt != 2'd0 ? lowEntry : '0;
  end
  dmem_store_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .pushCnt(pushCnt),
    .push0  (lowEntry),
    .push1  (highEntry),
    .pop    (pop),
    .head   (head),
    .second (second),
    .count  (count)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outQ <= '0;
      errQ <= 1'b0;
    end else begin
      outQ <= nextOut;
      errQ <= accept && dropErr;
    end
  end
  assign mem_req   = count != '0;
  assign buf_empty = count == '0;
  assign mem_addr  = {outQ.addr, 2'b00};
  assign mem_wdata = outQ.wdata;
  assign mem_wstrb = outQ.wstrb;
  assign st_err    = errQ;
endmodule

// File: tb/tb_dmem_store_unit.sv
// tb_dmem_store_unit: directed self-checking bench for the store unit write buffer
module tb_dmem_store_unit;
  logic clk = 1'b0;
  logic rst_n, st_valid, st_ready, mem_req, mem_ack, st_err, buf_empty;
  logic [31:0] st_addr, st_data, mem_addr, mem_wdata;
  logic [2:0] st_fmt;
  logic [3:0] mem_wstrb;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dmem_store_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_fmt   (st_fmt),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .st_err   (st_err),
    .buf_empty(buf_empty)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_wdata"}, mem_wdata, d);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(s));
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_fmt   = f;
    tick();
    st_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; st_valid = 1'b0; mem_ack = 1'b0;
    st_addr = '0; st_data = '0; st_fmt = '0;
    tick(); tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_err", 32'(st_err), 32'd0);
    check("rst_empty", 32'(buf_empty), 32'd1);
    check("rst_ready", 32'(st_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_idle", 32'(st_ready), 32'd1);
    // SB at offset 3; upper data bits must not leak into other lanes
    store(32'h103, 32'hFFFF_FFA5, 3'b000);
    head("sb", 32'h100, 32'hA500_0000, 4'b1000);
    check("sb_empty", 32'(buf_empty), 32'd0);
    check("sb_err", 32'(st_err), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_drained_req", 32'(mem_req), 32'd0);
    check("sb_drained_empty", 32'(buf_empty), 32'd1);
    store(32'h202, 32'h0000_1234, 3'b001);
    head("sh", 32'h200, 32'h1234_0000, 4'b1100);
`ifdef DMEM_STORE_SPLIT_EN
    check("sh_ready_split", 32'(st_ready), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    store(32'h300, 32'hDEAD_BEEF, 3'b010);
    head("sw", 32'h300, 32'hDEAD_BEEF, 4'b1111);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`else
    check("sh_ready", 32'(st_ready), 32'd1);
    store(32'h300, 32'hDEAD_BEEF, 3'b010);
    check("full_ready", 32'(st_ready), 32'd0);
    head("hold1", 32'h200, 32'h1234_0000, 4'b1100);
    tick();
    head("hold2", 32'h200, 32'h1234_0000, 4'b1100);
    mem_ack = 1'b1;
    tick();
    head("sw", 32'h300, 32'hDEAD_BEEF, 4'b1111);
    tick();
    mem_ack = 1'b0;
`endif
    check("pair_empty", 32'(buf_empty), 32'd1);
    check("pair_req", 32'(mem_req), 32'd0);
    store(32'h1FF, 32'h1122_3344, 3'b010);
`ifdef DMEM_STORE_SPLIT_EN
    check("split_err", 32'(st_err), 32'd0);
    head("split_lo", 32'h1FC, 32'h4400_0000, 4'b1000);
    mem_ack = 1'b1;
    tick();
    head("split_hi", 32'h200, 32'h0011_2233, 4'b0111);
    tick();
    mem_ack = 1'b0;
    check("split_done", 32'(buf_empty), 32'd1);
`else
    check("mis_err", 32'(st_err), 32'd1);
    check("mis_req", 32'(mem_req), 32'd0);
    check("mis_empty", 32'(buf_empty), 32'd1);
    tick();
    check("mis_err_pulse", 32'(st_err), 32'd0);
    check("mis_req2", 32'(mem_req), 32'd0);
`endif
    store(32'h100, 32'h5555_5555, 3'b101);
    check("ill_err", 32'(st_err), 32'd1);
    check("ill_req", 32'(mem_req), 32'd0);
    tick();
    check("ill_err_pulse", 32'(st_err), 32'd0);
    check("ill_req2", 32'(mem_req), 32'd0);
`ifndef DMEM_STORE_SPLIT_EN
    // push and pop in the same edge: count stays 1, new store becomes head
    store(32'h10, 32'h0000_0077, 3'b000);
    head("pp_first", 32'h10, 32'h0000_0077, 4'b0001);
    mem_ack = 1'b1;
    store(32'h22, 32'h0000_BEEF, 3'b001);
    head("pp_second", 32'h20, 32'hBEEF_0000, 4'b1100);
    tick();
    mem_ack = 1'b0;
    check("pp_empty", 32'(buf_empty), 32'd1);
`endif
    store(32'hFFFF_FFFF, 32'h0000_005A, 3'b000);
    head("wrap_sb", 32'hFFFF_FFFC, 32'h5A00_0000, 4'b1000);
    check("wrap_err", 32'(st_err), 32'd0);
    rst_n = 1'b0;
    tick();
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_empty", 32'(buf_empty), 32'd1);
    check("midrst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    tick(); tick();
    check("post_rst_req", 32'(mem_req), 32'd0);
    check("post_rst_empty", 32'(buf_empty), 32'd1);
    check("post_rst_wstrb", 32'(mem_wstrb), 32'd0);
    mem_ack = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
